// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the single-clock FIFO: owns the read pointer and
// presents memory words first-word-fall-through through a 2-entry output buffer.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 6
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf_err
);

  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic [1:0]          ocnt_q, ocnt_d;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] skid_q, skid_d;
  logic                out_valid_q, out_valid_d;
  logic                ovf_q, ovf_d;
  logic                pop, fetch;

  // Full (equal low bits, different wrap bit) is not empty, so compare all bits.
  assign rempty = rrst | (rptr_q == wptr);
  assign rlevel = wptr - rptr_q;
  assign pop    = out_valid_q & out_ready;
  assign fetch  = ~rempty & ~rrst & ((ocnt_q != 2'd2) | pop);

  assign raddr     = rptr_q[ADDRSIZE-1:0];
  assign rclken    = fetch;
  assign rptr      = rptr_q;
  assign out_data  = head_q;
  assign out_valid = out_valid_q;
  assign ovf_err   = ovf_q;

  always_comb begin
    rptr_d = rptr_q;
    head_d = head_q;
    skid_d = skid_q;
    ocnt_d = ocnt_q + {1'b0, fetch} - {1'b0, pop};
    ovf_d  = ovf_q | (rlevel > DEPTH);
    if (fetch) rptr_d = rptr_q + 1'b1;
    // Head always holds the oldest word; skid only ever holds the next one.
    if (fetch && !pop) begin
      if (ocnt_q == 2'd0) head_d = mem_rdata;
      else                skid_d = mem_rdata;
    end else if (pop && !fetch) begin
      head_d = skid_q;
    end else if (pop && fetch) begin
      if (ocnt_q == 2'd1) begin
        head_d = mem_rdata;
      end else begin
        head_d = skid_q;
        skid_d = mem_rdata;
      end
    end
    out_valid_d = (ocnt_d != 2'd0);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_q      <= '0;
      ocnt_q      <= '0;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      ocnt_q      <= ocnt_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: queue-based reader model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_fifo_rd_ctrl;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic [6:0]  wptr = '0;
  logic [31:0] mem_rdata;
  logic [5:0]  raddr;
  logic        rclken;
  logic [6:0]  rptr;
  logic        rempty;
  logic [6:0]  rlevel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf_err;

  logic [31:0] mem [64];
  assign mem_rdata = mem[raddr];

  fifo_rd_ctrl #(.DATASIZE(32), .ADDRSIZE(6)) dut (
    .rclk(rclk), .rrst(rrst), .wptr(wptr), .mem_rdata(mem_rdata),
    .raddr(raddr), .rclken(rclken), .rptr(rptr), .rempty(rempty),
    .rlevel(rlevel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_err(ovf_err)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reader model: words held for the consumer as a queue, pointer as a count.
  logic [6:0]  m_rptr;
  logic [31:0] m_buf[$];
  bit          m_ovf;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_fetch();
    return !rrst && (m_rptr != wptr) &&
           (m_buf.size() < 2 || (m_buf.size() != 0 && out_ready));
  endfunction

  always @(posedge rclk) begin
    if (rrst) begin
      m_buf.delete();
      m_rptr = '0;
      m_ovf  = 1'b0;
    end else begin
      bit f, p;
      logic [6:0] lv;
      f  = m_fetch();
      p  = (m_buf.size() != 0) && out_ready;
      lv = wptr - m_rptr;
      if (lv > 7'd64) m_ovf = 1'b1;
      if (p) void'(m_buf.pop_front());
      if (f) begin
        m_buf.push_back(mem[m_rptr[5:0]]);
        m_rptr = m_rptr + 7'd1;
      end
    end
  end

  always @(negedge rclk) begin
    if (cmp_en) begin
      logic [6:0] lv;
      lv = wptr - m_rptr;
      chk("rptr", rptr, m_rptr);
      chk("raddr", raddr, m_rptr[5:0]);
      chk("rempty", rempty, rrst || (m_rptr == wptr));
      chk("rlevel", rlevel, lv);
      chk("rclken", rclken, m_fetch());
      chk("out_valid", out_valid, m_buf.size() != 0);
      chk("ovf_err", ovf_err, m_ovf);
      if (m_buf.size() != 0) chk("out_data", out_data, m_buf[0]);
      if (out_valid && out_ready && exp_q.size() != 0)
        chk("order", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    mem[wptr[5:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 7'd1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wptr = '0;
    exp_q.delete();
    tick();
    rrst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) chk({name, "_timeout"}, cyc, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // 1: reset state
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_err, 0);
    rrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_rempty", rempty, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_rclken", rclken, 0);
      chk("idle_rptr", rptr, 0);
      chk("idle_rlevel", rlevel, 0);
    end

    // 2: single word latency
    write_word(32'hA5A5_0001);
    #3;
    chk("t2_rclken", rclken, 1);
    chk("t2_rempty_pre", rempty, 0);
    tick();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 32'hA5A5_0001);
    chk("t2_rptr", rptr, 1);
    chk("t2_rempty", rempty, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_popped", out_valid, 0);

    // 3: backpressure then burst drain
    for (int i = 0; i < 10; i++) begin
      write_word(32'h3000_0000 + i);
      tick();
    end
    tick(); tick();
    chk("t3_rptr", rptr, 3);
    chk("t3_rlevel", rlevel, 8);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 32'h3000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_burst_valid", out_valid, 1);
      chk("t3_burst_data", out_data, 32'h3000_0000 + i);
      tick();
    end
    out_ready = 1'b0;
    chk("t3_drained", out_valid, 0);

    // 4: 200 words with random backpressure, pointer wraps 127->0
    begin
      int sent = 0;
      int cyc = 0;
      while ((sent < 200 || m_buf.size() != 0 || wptr != m_rptr) && cyc < 5000) begin
        logic [6:0] lv;
        lv = wptr - m_rptr;
        out_ready = 1'($urandom_range(0, 1));
        if (sent < 200 && $urandom_range(0, 1) == 1 && lv < 7'd64) begin
          write_word($urandom);
          sent++;
        end
        tick();
        cyc++;
      end
      if (cyc >= 5000) chk("t4_timeout", cyc, 0);
      out_ready = 1'b0;
      chk("t4_rptr", rptr, 83);
      chk("t4_ovf", ovf_err, 0);
      chk("t4_left", exp_q.size(), 0);
    end

    // 5: full memory, then overrun
    do_reset();
    wptr = 7'd64;
    #1;
    chk("t5_rempty", rempty, 0);
    chk("t5_rlevel", rlevel, 64);
    chk("t5_rptr", rptr, 0);
    wptr = 7'd65;
    tick(); tick(); tick();
    chk("t5_ovf_set", ovf_err, 1);
    tick(); tick();
    chk("t5_ovf_sticky", ovf_err, 1);
    do_reset();
    chk("t5_ovf_clr", ovf_err, 0);

    // 6: reset mid-stream with a full output buffer
    for (int i = 0; i < 7; i++) begin
      write_word(32'h6000_0000 + i);
      tick();
    end
    tick(); tick();
    chk("t6_rptr", rptr, 2);
    chk("t6_rlevel", rlevel, 5);
    chk("t6_out_data", out_data, 32'h6000_0000);
    rrst = 1'b1;
    #3;
    chk("t6_rst_rclken", rclken, 0);
    chk("t6_rst_rempty", rempty, 1);
    tick();
    rrst = 1'b0;
    wptr = '0;
    exp_q.delete();
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_rptr0", rptr, 0);
    chk("t6_rclken", rclken, 0);
    for (int i = 0; i < 5; i++) begin
      write_word(32'h7000_0000 + i);
      tick();
    end
    drain("t6", 50);
    chk("t6_resume_rptr", rptr, 5);
    chk("t6_left", exp_q.size(), 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
